iter_muldiv: RTL and testbench

ITER_MULDIV -- requirements
Module: iter_muldiv

---
 rtl/iter_muldiv.sv | 196 +++++++++++++++++++
 tb/tb_iter_muldiv.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_muldiv.sv
`default_nettype none
// ============================================================================
//  Module   : iter_muldiv
//  Purpose  : Iterative 16x16 unsigned multiplier / divider. One shift-add
//             (MUL) or restoring-division (DIV/MOD) step per clock, 16 steps
//             per operation, with a short-cut path for division by zero.
//             Result and {ZF,NF,CF,OF} flags are registered on DONE entry.
//  Revision : 1.0 - initial release
// ============================================================================
module iter_muldiv (
    input  logic        clk,
    input  logic        rst,      // asynchronous, active-low
    input  logic [1:0]  op,
    input  logic [15:0] srcA,
    input  logic [15:0] srcB,
    output logic        ready,
    output logic [15:0] result,
    output logic [3:0]  flags
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_t;

    localparam logic [1:0]  OP_NONE       = 2'b00;
    localparam logic [1:0]  OP_MUL        = 2'b01;
    localparam logic [1:0]  OP_DIV        = 2'b10;
    localparam logic [1:0]  OP_MOD        = 2'b11;
    localparam logic [3:0]  LAST_ITER     = 4'd15;
    localparam logic [15:0] DIV0_QUOTIENT = 16'hFFFF;

    // Architectural state
    state_t      state_q,  state_d;
    logic [3:0]  cnt_q,    cnt_d;     // iteration index 0..15
    logic [1:0]  op_q,     op_d;      // operation captured at request
    logic [15:0] a_q,      a_d;       // MUL: multiplicand; DIV: dividend shifting into quotient
    logic [15:0] b_q,      b_d;       // multiplier / divisor
    logic [31:0] prod_q,   prod_d;    // MUL partial product
    logic [15:0] rem_q,    rem_d;     // DIV partial remainder
    logic [15:0] result_q, result_d;
    logic [3:0]  flags_q,  flags_d;

    // Single-iteration datapath values
    logic [31:0] w_addend;
    logic [31:0] w_prod_next;
    logic [16:0] w_rem_shift;
    logic        w_sub_ok;
    logic [15:0] w_rem_next;
    logic [15:0] w_quo_next;
    logic        w_div_by_zero;

    // Flag vector {ZF, NF, CF, OF} for a given result value
    function automatic logic [3:0] mk_flags(input logic [15:0] r,
                                            input logic        cf,
                                            input logic        of);
        return {(r == 16'h0000), r[15], cf, of};
    endfunction

    // One step of shift-add multiply and one step of restoring division
    always_comb begin
        w_addend    = b_q[cnt_q] ? ({16'h0000, a_q} << cnt_q) : 32'h0000_0000;
        w_prod_next = prod_q + w_addend;

        // Bring the next dividend bit into the remainder, then try subtracting
        w_rem_shift = {rem_q, a_q[15]};
        w_sub_ok    = (w_rem_shift >= {1'b0, b_q});
        w_rem_next  = w_sub_ok ? 16'(w_rem_shift - {1'b0, b_q}) : w_rem_shift[15:0];
        w_quo_next  = {a_q[14:0], w_sub_ok};
    end

    // Division-by-zero is detected on the live request so it can bypass BUSY
    always_comb begin
        w_div_by_zero = ((op == OP_DIV) || (op == OP_MOD)) && (srcB == 16'h0000);
    end

    // Next-state and next-register computation
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        prod_d   = prod_q;
        rem_d    = rem_q;
        result_d = result_q;
        flags_d  = flags_q;

        case (state_q)
            S_IDLE: begin
                if (op != OP_NONE) begin
                    op_d   = op;
                    a_d    = srcA;
                    b_d    = srcB;
                    cnt_d  = 4'd0;
                    prod_d = 32'h0000_0000;
                    rem_d  = 16'h0000;
                    if (w_div_by_zero) begin
                        // Short-cut: result is defined directly from the operands
                        state_d = S_DONE;
                        if (op == OP_DIV) begin
                            result_d = DIV0_QUOTIENT;
                            flags_d  = mk_flags(DIV0_QUOTIENT, 1'b0, 1'b1);
                        end else begin
                            result_d = srcA;
                            flags_d  = mk_flags(srcA, 1'b0, 1'b1);
                        end
                    end else begin
                        state_d = S_BUSY;
                    end
                end
            end

            S_BUSY: begin
                if (op == OP_NONE) begin
                    // Abort: drop the operation, leave result/flags untouched
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                    if (op_q == OP_MUL) begin
                        prod_d = w_prod_next;
                    end else begin
                        a_d   = w_quo_next;
                        rem_d = w_rem_next;
                    end

                    if (cnt_q == LAST_ITER) begin
                        // Final step: publish straight from this step's output
                        state_d = S_DONE;
                        case (op_q)
                            OP_MUL: begin
                                result_d = w_prod_next[15:0];
                                flags_d  = mk_flags(w_prod_next[15:0],
                                                    |w_prod_next[31:16],
                                                    |w_prod_next[31:16]);
                            end
                            OP_DIV: begin
                                result_d = w_quo_next;
                                flags_d  = mk_flags(w_quo_next, 1'b0, 1'b0);
                            end
                            default: begin
                                result_d = w_rem_next;
                                flags_d  = mk_flags(w_rem_next, 1'b0, 1'b0);
                            end
                        endcase
                    end
                end
            end

            S_DONE: begin
                // Result is presented for exactly one cycle; requests are not taken here
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared by the asynchronous reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            op_q     <= OP_NONE;
            a_q      <= 16'h0000;
            b_q      <= 16'h0000;
            prod_q   <= 32'h0000_0000;
            rem_q    <= 16'h0000;
            result_q <= 16'h0000;
            flags_q  <= 4'b0000;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            prod_q   <= prod_d;
            rem_q    <= rem_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    // Ready is low from the request cycle onward and high again in DONE
    always_comb begin
        ready = ((state_q == S_IDLE) && (op == OP_NONE)) || (state_q == S_DONE);
    end

    assign result = result_q;
    assign flags  = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_iter_muldiv.sv
`default_nettype none
// ============================================================================
//  Module   : tb_iter_muldiv
//  Purpose  : Self-checking bench for iter_muldiv: directed vector table,
//             multi-cycle corner sequences and randomized operations checked
//             against an arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_iter_muldiv;

    logic        clk;
    logic        rst;
    logic [1:0]  op;
    logic [15:0] srcA;
    logic [15:0] srcB;
    logic        ready;
    logic [15:0] result;
    logic [3:0]  flags;

    int checks = 0;
    int errors = 0;

    iter_muldiv dut (
        .clk    (clk),
        .rst    (rst),
        .op     (op),
        .srcA   (srcA),
        .srcB   (srcB),
        .ready  (ready),
        .result (result),
        .flags  (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [3:0]  fl;
        int          lat;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain arithmetic on the operands
    function automatic void model(input logic [1:0] o, input logic [15:0] a,
                                  input logic [15:0] b, output logic [15:0] res,
                                  output logic [3:0] fl, output int lat);
        logic [31:0] p;
        logic        cf;
        logic        of;
        lat = 17;
        cf  = 1'b0;
        of  = 1'b0;
        case (o)
            2'b01: begin
                p   = {16'h0, a} * {16'h0, b};
                res = p[15:0];
                cf  = (p > 32'h0000_FFFF);
                of  = cf;
            end
            2'b10: begin
                if (b == 16'h0) begin res = 16'hFFFF; of = 1'b1; lat = 1; end
                else res = a / b;
            end
            default: begin
                if (b == 16'h0) begin res = a; of = 1'b1; lat = 1; end
                else res = a % b;
            end
        endcase
        fl = {(res == 16'h0), res[15], cf, of};
    endfunction

    // Count edges from the request cycle until ready rises (bounded)
    task automatic wait_ready(input bit scramble, output int n);
        n = 0;
        while (1) begin
            tick();
            n++;
            if (ready || n >= 40) break;
            if (scramble) begin
                srcA = 16'($urandom);
                srcB = 16'($urandom);
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input string name, input bit scramble);
        int n;
        logic [15:0] held;
        op   = v.op;
        srcA = v.a;
        srcB = v.b;
        #1;
        chk($sformatf("%s req_ready", name), {31'h0, ready}, 32'h0);
        wait_ready(scramble, n);
        chk($sformatf("%s latency", name), n, v.lat);
        chk($sformatf("%s result", name), {16'h0, result}, {16'h0, v.res});
        chk($sformatf("%s flags", name), {28'h0, flags}, {28'h0, v.fl});
        held = result;
        op   = 2'b00;
        tick();
        chk($sformatf("%s idle_ready", name), {31'h0, ready}, 32'h1);
        chk($sformatf("%s held", name), {16'h0, result}, {16'h0, held});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          n;
        int          sel;
        bit          changed;
        vec_t        v;
        logic [15:0] prev_res;
        logic [3:0]  prev_fl;

        tbl[0]  = '{2'b01, 16'd300,   16'd200,   16'hEA60, 4'b0100, 17};
        tbl[1]  = '{2'b01, 16'h0100,  16'h0100,  16'h0000, 4'b1011, 17};
        tbl[2]  = '{2'b10, 16'd1000,  16'd7,     16'h008E, 4'b0000, 17};
        tbl[3]  = '{2'b11, 16'd1000,  16'd7,     16'h0006, 4'b0000, 17};
        tbl[4]  = '{2'b10, 16'd5,     16'd0,     16'hFFFF, 4'b0101, 1};
        tbl[5]  = '{2'b11, 16'd5,     16'd0,     16'h0005, 4'b0001, 1};
        tbl[6]  = '{2'b01, 16'h0000,  16'h0000,  16'h0000, 4'b1000, 17};
        tbl[7]  = '{2'b01, 16'hFFFF,  16'hFFFF,  16'h0001, 4'b0011, 17};
        tbl[8]  = '{2'b10, 16'hFFFF,  16'h0001,  16'hFFFF, 4'b0100, 17};
        tbl[9]  = '{2'b11, 16'h8000,  16'hFFFF,  16'h8000, 4'b0100, 17};
        tbl[10] = '{2'b10, 16'd3,     16'd5,     16'h0000, 4'b1000, 17};
        tbl[11] = '{2'b11, 16'h0000,  16'h0000,  16'h0000, 4'b1001, 1};
        tbl[12] = '{2'b01, 16'h8000,  16'h0001,  16'h8000, 4'b0100, 17};

        // Reset state
        rst  = 1'b0;
        op   = 2'b00;
        srcA = 16'h0;
        srcB = 16'h0;
        tick();
        tick();
        chk("reset ready", {31'h0, ready}, 32'h1);
        chk("reset result", {16'h0, result}, 32'h0);
        chk("reset flags", {28'h0, flags}, 32'h0);
        rst = 1'b1;
        tick();
        chk("post_reset ready", {31'h0, ready}, 32'h1);

        // Directed table
        for (int i = 0; i < 13; i++) begin
            run_vec(tbl[i], $sformatf("vec%0d", i), 1'b0);
        end

        // Back-to-back: MUL then DIV presented in the DONE cycle
        op = 2'b01; srcA = 16'd300; srcB = 16'd200;
        wait_ready(1'b0, n);
        chk("b2b mul latency", n, 17);
        chk("b2b mul result", {16'h0, result}, 32'hEA60);
        op = 2'b10; srcA = 16'd1000; srcB = 16'd7;
        #1;
        chk("b2b done ready", {31'h0, ready}, 32'h1);
        tick();
        chk("b2b done one cycle", {31'h0, ready}, 32'h0);
        chk("b2b idle result", {16'h0, result}, 32'hEA60);
        wait_ready(1'b0, n);
        chk("b2b div latency", n, 17);
        chk("b2b div result", {16'h0, result}, 32'h008E);
        chk("b2b div flags", {28'h0, flags}, 32'h0);
        op = 2'b00;
        tick();
        chk("b2b after ready", {31'h0, ready}, 32'h1);

        // Abort in the fifth BUSY cycle
        prev_res = result;
        prev_fl  = flags;
        op = 2'b01; srcA = 16'd300; srcB = 16'd200;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("abort busy%0d ready", i), {31'h0, ready}, 32'h0);
        end
        op = 2'b00;
        #1;
        chk("abort busy ignores op", {31'h0, ready}, 32'h0);
        tick();
        chk("abort ready", {31'h0, ready}, 32'h1);
        chk("abort result", {16'h0, result}, {16'h0, prev_res});
        chk("abort flags", {28'h0, flags}, {28'h0, prev_fl});
        changed = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!ready || result !== prev_res) changed = 1'b1;
        end
        chk("abort no done", {31'h0, changed}, 32'h0);
        run_vec(tbl[3], "after_abort", 1'b0);

        // Reset in the eighth BUSY cycle
        op = 2'b01; srcA = 16'd300; srcB = 16'd200;
        for (int i = 0; i < 8; i++) tick();
        rst = 1'b0;
        op  = 2'b00;
        #1;
        chk("midreset ready", {31'h0, ready}, 32'h1);
        chk("midreset result", {16'h0, result}, 32'h0);
        chk("midreset flags", {28'h0, flags}, 32'h0);
        tick();
        tick();
        rst = 1'b1;
        changed = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!ready || result !== 16'h0 || flags !== 4'h0) changed = 1'b1;
        end
        chk("midreset no done", {31'h0, changed}, 32'h0);
        run_vec(tbl[0], "after_reset", 1'b0);

        // Randomized operations against the reference model
        for (int i = 0; i < 60; i++) begin
            v.op = 2'($urandom_range(1, 3));
            sel  = $urandom_range(0, 7);
            v.a  = 16'($urandom);
            if (sel == 0)      v.b = 16'h0;
            else if (sel == 1) v.b = 16'($urandom_range(1, 15));
            else if (sel == 2) begin v.a = 16'($urandom_range(0, 255)); v.b = 16'($urandom_range(0, 255)); end
            else               v.b = 16'($urandom);
            model(v.op, v.a, v.b, v.res, v.fl, v.lat);
            run_vec(v, $sformatf("rnd%0d op%0d a%0h b%0h", i, v.op, v.a, v.b), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
